// File: rtl/mips_trace_buffer.sv
// Instruction-retire trace buffer for the single-cycle MIPS core.
// Captures filtered PC/instr/memwrite history, freezes on trigger or stop, drains oldest-first.
module mips_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = DEPTH / 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [31:0]                pc_in,
  input  logic [31:0]                instr_in,
  input  logic                       memwrite_in,
  input  logic [1:0]                 mode,
  input  logic                       trig_en,
  input  logic [31:0]                trig_pc,
  input  logic                       start,
  input  logic                       stop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_mw,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       triggered,
  output logic                       wrapped,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] PT   = CW'(POST_TRIG);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    POST,
    FROZEN,
    DRAIN
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] wr_ptr, wr_ptr_nx;
  logic [AW-1:0] rd_ptr, rd_ptr_nx;
  logic [CW-1:0] count_q, count_nx;
  logic [CW-1:0] remain, remain_nx;
  logic [CW-1:0] post_cnt, post_nx;
  logic          trig_q, trig_nx;
  logic          wrap_q, wrap_nx;

  logic [64:0]   mem [DEPTH];
  logic [64:0]   entry;

  logic [5:0]    opcode;
  logic          is_cti;
  logic          match;
  logic          capturing;
  logic          store;
  logic          pc_hit;

  assign opcode    = instr_in[31:26];
  assign is_cti    = (opcode == 6'b000100) ||
                     (opcode == 6'b000101) ||
                     (opcode == 6'b000010);
  assign capturing = (state == CAPTURE) || (state == POST);
  assign pc_hit    = trig_en && (pc_in == trig_pc);

  always_comb begin
    match = 1'b0;
    unique case (mode)
      2'b00:   match = 1'b1;
      2'b01:   match = is_cti;
      2'b10:   match = memwrite_in;
      default: match = 1'b0;
    endcase
  end

  assign store = capturing && valid_in && match;

  always_comb begin
    state_nx  = state;
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    count_nx  = count_q;
    remain_nx = remain;
    post_nx   = post_cnt;
    trig_nx   = trig_q;
    wrap_nx   = wrap_q;

    // A full buffer keeps its count; the write lands on the oldest slot.
    if (store) begin
      wr_ptr_nx = wr_ptr + 1'b1;
      if (count_q == FULL) begin
        wrap_nx = 1'b1;
      end else begin
        count_nx = count_q + 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
      end
      CAPTURE: begin
        if (store && pc_hit) begin
          trig_nx = 1'b1;
          if (PT == '0) begin
            state_nx = FROZEN;
          end else begin
            state_nx = POST;
            post_nx  = '0;
          end
        end
        if (stop) begin
          state_nx = FROZEN;
        end
      end
      POST: begin
        if (store) begin
          post_nx = post_cnt + 1'b1;
          if (post_nx == PT) begin
            state_nx = FROZEN;
          end
        end
        if (stop) begin
          state_nx = FROZEN;
        end
      end
      FROZEN: begin
        if (count_q != '0) begin
          state_nx  = DRAIN;
          rd_ptr_nx = wr_ptr - count_q[AW-1:0];
          remain_nx = count_q;
        end else begin
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          rd_ptr_nx = rd_ptr + 1'b1;
          remain_nx = remain - 1'b1;
          if (remain == CW'(1)) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (start) begin
      state_nx  = CAPTURE;
      wr_ptr_nx = '0;
      count_nx  = '0;
      remain_nx = '0;
      post_nx   = '0;
      trig_nx   = 1'b0;
      wrap_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      remain   <= '0;
      post_cnt <= '0;
      trig_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      count_q  <= count_nx;
      remain   <= remain_nx;
      post_cnt <= post_nx;
      trig_q   <= trig_nx;
      wrap_q   <= wrap_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && store && !start) begin
      mem[wr_ptr] <= {memwrite_in, instr_in, pc_in};
    end
  end

  assign entry     = mem[rd_ptr];
  assign out_valid = (state == DRAIN);
  assign out_pc    = out_valid ? entry[31:0]  : '0;
  assign out_instr = out_valid ? entry[63:32] : '0;
  assign out_mw    = out_valid ? entry[64]    : 1'b0;
  assign out_last  = out_valid && (remain == CW'(1));

  assign count     = count_q;
  assign triggered = trig_q;
  assign wrapped   = wrap_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Scoreboard bench for mips_trace_buffer: queue-based history model,
// directed scenarios plus randomized capture sessions and backpressure.
module tb_mips_trace_buffer;

  localparam int DEPTH = 8;
  localparam int PT    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        memwrite_in = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_mw;
  logic        out_last;
  logic [3:0]  count;
  logic        triggered;
  logic        wrapped;
  logic        busy;

  always #5 clk = ~clk;

  mips_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(PT)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
    .instr_in(instr_in), .memwrite_in(memwrite_in), .mode(mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .start(start), .stop(stop),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_mw(out_mw), .out_last(out_last),
    .count(count), .triggered(triggered), .wrapped(wrapped), .busy(busy)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mw;
  } ent_t;

  typedef struct {
    ent_t e;
    logic last;
  } exp_t;

  ent_t hist[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_phase = 0;
  bit   m_trig = 0;
  bit   m_wrap = 0;
  int   m_post = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit filt(logic [1:0] md, logic [31:0] ins, logic w);
    case (md)
      2'b00:   return 1'b1;
      2'b01:   return ins[31:26] inside {6'h04, 6'h05, 6'h02};
      2'b10:   return w;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: phase 1 capture, 2 post-trigger, 3 frozen; history is a bounded queue.
  task automatic step(bit v, logic [31:0] pc, logic [31:0] ins, bit w, bit stp);
    int   ph;
    bit   st;
    ent_t e;
    ph = m_phase;
    valid_in = v; pc_in = pc; instr_in = ins; memwrite_in = w; stop = stp;
    if (ph == 1 || ph == 2) begin
      st = v && filt(mode, ins, w);
      if (st) begin
        e.pc = pc; e.instr = ins; e.mw = w;
        hist.push_back(e);
        if (hist.size() > DEPTH) begin
          void'(hist.pop_front());
          m_wrap = 1;
        end
      end
      if (ph == 1 && st && trig_en && pc == trig_pc) begin
        m_trig = 1;
        if (PT == 0) m_phase = 3;
        else begin
          m_phase = 2;
          m_post = 0;
        end
      end else if (ph == 2 && st) begin
        m_post++;
        if (m_post == PT) m_phase = 3;
      end
      if (stp) m_phase = 3;
    end
    tick();
    valid_in = 0; stop = 0; memwrite_in = 0;
    if (m_phase != 0) chk("count", count, hist.size());
  endtask

  task automatic begin_session(logic [1:0] md, bit te, logic [31:0] tp);
    out_ready = 0;
    mode = md; trig_en = te; trig_pc = tp; start = 1;
    hist.delete();
    m_phase = 1; m_trig = 0; m_wrap = 0; m_post = 0;
    tick();
    start = 0;
    exp_q.delete();
    chk("start_count", count, 0);
    chk("start_busy", busy, 1);
    chk("start_valid", out_valid, 0);
    chk("start_trig", triggered, 0);
  endtask

  task automatic freeze_load();
    exp_t x;
    chk("frz_trig", triggered, m_trig);
    chk("frz_wrap", wrapped, m_wrap);
    chk("frz_busy", busy, 1);
    chk("frz_phase", (m_phase == 3), 1);
    for (int i = 0; i < hist.size(); i++) begin
      x.e = hist[i];
      x.last = (i == hist.size() - 1);
      exp_q.push_back(x);
    end
    hist.delete();
    m_phase = 0;
  endtask

  // rmode: 0 ready held high, 1 random ready, 2 ready low for three drain cycles.
  task automatic drain(int rmode);
    int i;
    freeze_load();
    i = 0;
    do begin
      case (rmode)
        0:       out_ready = 1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = !(i >= 2 && i < 5);
      endcase
      valid_in = $urandom_range(0, 1);
      pc_in = $urandom; instr_in = $urandom;
      memwrite_in = $urandom_range(0, 1);
      stop = $urandom_range(0, 1);
      tick();
      i++;
    end while ((exp_q.size() > 0 || i < 2) && i < 100);
    valid_in = 0; stop = 0; memwrite_in = 0; out_ready = 0;
    if (exp_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL out_unexpected: got pc %0h expected no entry", out_pc);
      end else begin
        chk("out_pc", out_pc, exp_q[0].e.pc);
        chk("out_instr", out_instr, exp_q[0].e.instr);
        chk("out_mw", out_mw, exp_q[0].e.mw);
        chk("out_last", out_last, exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("out_zero", {out_pc, out_instr, out_mw, out_last}, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] fstream [4];
  logic [5:0]  ops [6];

  initial begin
    fstream[0] = 32'h20080005;
    fstream[1] = 32'h1509FFFE;
    fstream[2] = 32'hAD090004;
    fstream[3] = 32'h08000000;
    ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h05;
    ops[3] = 6'h02; ops[4] = 6'h2B; ops[5] = 6'h23;

    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_wrap", wrapped, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1;
    tick();

    // basic capture
    begin_session(2'b00, 0, 0);
    step(1, 32'h00, 32'h20080005, 0, 0);
    step(1, 32'h04, 32'h20090001, 0, 0);
    step(1, 32'h08, 32'h01095020, 0, 0);
    chk("basic_count", count, 3);
    step(0, 0, 0, 0, 1);
    drain(0);

    // wrap
    begin_session(2'b00, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 32'(4 * i), $urandom, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("wrap_flag", wrapped, 1);
    chk("wrap_count", count, 8);
    drain(0);

    // trigger with post-trigger depth
    begin_session(2'b00, 1, 32'h14);
    for (int i = 0; i < 20 && m_phase != 3; i++) step(1, 32'(4 * i), $urandom, 0, 0);
    chk("trig_flag", triggered, 1);
    chk("trig_wrap", wrapped, 0);
    chk("trig_count", count, 8);
    drain(1);

    // filters
    begin_session(2'b01, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), fstream[i], (i == 2), 0);
    step(0, 0, 0, 0, 1);
    chk("filt_cti_count", count, 2);
    drain(0);
    begin_session(2'b10, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), fstream[i], (i == 2), 0);
    step(0, 0, 0, 0, 1);
    chk("filt_mw_count", count, 1);
    drain(2);

    // abort mid-drain by start
    begin_session(2'b00, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'(32'h100 + 4 * i), $urandom, 0, 0);
    step(0, 0, 0, 0, 1);
    freeze_load();
    out_ready = 1;
    tick(); tick(); tick();
    chk("abort_pre_valid", out_valid, 1);
    begin_session(2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'(32'h200 + 4 * i), $urandom, 1, 0);
    step(0, 0, 0, 0, 1);
    drain(0);

    // reset mid-drain
    begin_session(2'b00, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'(32'h300 + 4 * i), $urandom, 0, 0);
    step(0, 0, 0, 0, 1);
    freeze_load();
    out_ready = 1;
    tick(); tick(); tick();
    out_ready = 0;
    reset = 0;
    tick();
    exp_q.delete();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_count", count, 0);
    chk("rst2_out", {out_pc, out_instr}, 0);
    reset = 1;
    tick();

    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      int len;
      begin_session(2'($urandom_range(0, 3)), $urandom_range(0, 1),
                    32'(4 * $urandom_range(0, 15)));
      len = $urandom_range(1, 30);
      for (int i = 0; i < len && m_phase != 3; i++) begin
        step($urandom_range(0, 3) != 0,
             32'(4 * $urandom_range(0, 15)),
             {ops[$urandom_range(0, 5)], 26'($urandom)},
             $urandom_range(0, 1),
             $urandom_range(0, 40) == 0);
      end
      if (m_phase != 3) step(0, 0, 0, 0, 1);
      drain(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
